// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and byte-lane decode for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Little-endian lane enables; sub-size low address bits are ignored.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lane;
      HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// 32-bit word array: byte-enabled synchronous write, asynchronous read.
module ahb_sram_array #(
  parameter int WORD_AW = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [WORD_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**WORD_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR.
// Optional macro AHB_SRAM_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;
  localparam logic [2:0] WS      = 3'(WAIT_STATES);

  logic [1:0]        state;
  logic [2:0]        wait_cnt;
  logic              vld_p1;
  logic              write_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        size_p1;
  logic              accept;
  logic              err_p0;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              unused_inputs;

  assign unused_inputs = ^{HADDR[31:ADDR_W], HBURST, HPROT, HMASTLOCK};

  assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign accept    = HSEL & HREADY & HREADYOUT &
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  // ---- address phase (p0) ----
  always_comb begin
    err_p0 = (HSIZE > HSIZE_WORD);
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    if ((HSIZE == HSIZE_HALF) && HADDR[0]) err_p0 = 1'b1;
    if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) err_p0 = 1'b1;
`endif
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      addr_p1  <= '0;
      size_p1  <= 3'd0;
    end else begin
      if (accept) begin
        addr_p1  <= HADDR[ADDR_W-1:0];
        write_p1 <= HWRITE;
        size_p1  <= HSIZE;
      end
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) state <= ST_IDLE;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          // IDLE and ERR2 are both ready cycles that may take a new address phase.
          if (accept && err_p0) begin
            state  <= ST_ERR1;
            vld_p1 <= 1'b0;
          end else if (accept && (WS != 3'd0)) begin
            state    <= ST_WAIT;
            wait_cnt <= WS;
            vld_p1   <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            vld_p1 <= accept;
          end
        end
      endcase
    end
  end

  // ---- data phase (p1): write commits on the completion edge only ----
  assign mem_we = HRESETn & vld_p1 & write_p1 & (state == ST_IDLE);
  assign mem_be = byte_en(size_p1, addr_p1[1:0]);
  assign HRDATA = (vld_p1 & ~write_p1) ? mem_rdata : 32'd0;

  ahb_sram_array #(
    .WORD_AW (ADDR_W-2)
  ) u_array (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (addr_p1[ADDR_W-1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances with 0, 2 and 3 wait states.
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        sel0, sel2, sel3;
  logic        ro0, ro2, ro3;
  logic        rs0, rs2, rs3;
  logic [31:0] rd0, rd2, rd3;
  int total;
  int bad;

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(HTRANS), .HMASTLOCK(1'b0),
    .HREADY(ro0), .HWDATA(HWDATA), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(HTRANS), .HMASTLOCK(1'b0),
    .HREADY(ro2), .HWDATA(HWDATA), .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2));

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel3), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(HTRANS), .HMASTLOCK(1'b0),
    .HREADY(ro3), .HWDATA(HWDATA), .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_ph(input int d, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [1:0] tr);
    sel0   = (d == 0);
    sel2   = (d == 2);
    sel3   = (d == 3);
    HWRITE = wr;
    HADDR  = a;
    HSIZE  = sz;
    HTRANS = tr;
  endtask

  task automatic bus_idle;
    sel0   = 1'b0;
    sel2   = 1'b0;
    sel3   = 1'b0;
    HTRANS = HTRANS_IDLE;
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? ro0 : ((d == 2) ? ro2 : ro3);
  endfunction

  task automatic wait_rdy(input int d);
    int n;
    n = 0;
    while (rdy_of(d) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (rdy_of(d) !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_rdy dut%0d: ready never returned within 20 cycles", d);
    end
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    tick();
    tick();
    total++; if (ro0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%0b exp=1", ro0); end
    total++; if (rs0 !== 1'b0) begin bad++; $display("FAIL reset_resp0 got=%0b exp=0", rs0); end
    total++; if (rd0 !== 32'd0) begin bad++; $display("FAIL reset_rdata0 got=%h exp=0", rd0); end
    total++; if (ro3 !== 1'b1 || rs3 !== 1'b0 || rd3 !== 32'd0) begin
      bad++; $display("FAIL reset_dut3 got ready=%0b resp=%0b rdata=%h exp 1/0/0", ro3, rs3, rd3); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    addr_ph(0, 1'b1, 32'h010, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'hDEADBEEF;
    addr_ph(0, 1'b0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    total++; if (ro0 !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", ro0); end
    total++; if (rs0 !== 1'b0) begin bad++; $display("FAIL b2b_resp got=%0b exp=0", rs0); end
    total++; if (rd0 !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_rdata got=%h exp=deadbeef", rd0); end
    tick();
    total++; if (rd0 !== 32'd0) begin bad++; $display("FAIL b2b_idle_rdata got=%h exp=0", rd0); end
  endtask

  task automatic test_byte_lanes;
    addr_ph(0, 1'b1, 32'h010, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'h11223344;
    addr_ph(0, 1'b1, 32'h013, HSIZE_BYTE, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'hAA000000;
    addr_ph(0, 1'b0, 32'h010, HSIZE_WORD, HTRANS_SEQ);
    tick();
    bus_idle();
    total++; if (rd0 !== 32'hAA223344) begin bad++; $display("FAIL byte_write got=%h exp=aa223344", rd0); end
    tick();
    addr_ph(0, 1'b1, 32'h012, HSIZE_HALF, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'h55667788;
    addr_ph(0, 1'b0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    total++; if (rd0 !== 32'h55663344) begin bad++; $display("FAIL half_write got=%h exp=55663344", rd0); end
    tick();
    addr_ph(0, 1'b1, 32'h414, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'h0F1E2D3C;
    addr_ph(0, 1'b0, 32'h014, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    total++; if (rd0 !== 32'h0F1E2D3C) begin bad++; $display("FAIL addr_wrap got=%h exp=0f1e2d3c", rd0); end
    tick();
    addr_ph(0, 1'b0, 32'h010, HSIZE_WORD, HTRANS_BUSY);
    tick();
    bus_idle();
    total++; if (rd0 !== 32'd0 || ro0 !== 1'b1) begin
      bad++; $display("FAIL busy_no_dphase got rdata=%h ready=%0b exp 0/1", rd0, ro0); end
  endtask

  task automatic test_wait_states;
    int lowcnt;
    addr_ph(3, 1'b1, 32'h040, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    HWDATA = 32'h0C0FFEE0;
    wait_rdy(3);
    addr_ph(3, 1'b0, 32'h040, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    lowcnt = 0;
    for (int i = 0; i < 20 && ro3 === 1'b0; i++) begin
      lowcnt++;
      tick();
    end
    total++; if (lowcnt != 3) begin bad++; $display("FAIL wait_low_cycles got=%0d exp=3", lowcnt); end
    total++; if (ro3 !== 1'b1 || rs3 !== 1'b0) begin
      bad++; $display("FAIL wait_complete got ready=%0b resp=%0b exp 1/0", ro3, rs3); end
    total++; if (rd3 !== 32'h0C0FFEE0) begin bad++; $display("FAIL wait_rdata got=%h exp=0c0ffee0", rd3); end
    tick();
  endtask

  task automatic test_error;
    addr_ph(0, 1'b1, 32'h020, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'h12345678;
    addr_ph(0, 1'b1, 32'h020, 3'd3, HTRANS_NONSEQ);
    tick();
    bus_idle();
    HWDATA = 32'hFFFFFFFF;
    total++; if (ro0 !== 1'b0 || rs0 !== 1'b1) begin
      bad++; $display("FAIL err1 got ready=%0b resp=%0b exp 0/1", ro0, rs0); end
    tick();
    total++; if (ro0 !== 1'b1 || rs0 !== 1'b1) begin
      bad++; $display("FAIL err2 got ready=%0b resp=%0b exp 1/1", ro0, rs0); end
    addr_ph(0, 1'b0, 32'h020, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    total++; if (ro0 !== 1'b1 || rs0 !== 1'b0) begin
      bad++; $display("FAIL err_after got ready=%0b resp=%0b exp 1/0", ro0, rs0); end
    total++; if (rd0 !== 32'h12345678) begin bad++; $display("FAIL err_nowrite got=%h exp=12345678", rd0); end
    tick();
  endtask

  task automatic test_align;
    addr_ph(0, 1'b1, 32'h000, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'hCAFEF00D;
    addr_ph(0, 1'b0, 32'h002, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    total++; if (ro0 !== 1'b0 || rs0 !== 1'b1) begin
      bad++; $display("FAIL align_err1 got ready=%0b resp=%0b exp 0/1", ro0, rs0); end
    tick();
    total++; if (ro0 !== 1'b1 || rs0 !== 1'b1) begin
      bad++; $display("FAIL align_err2 got ready=%0b resp=%0b exp 1/1", ro0, rs0); end
    tick();
    total++; if (rs0 !== 1'b0) begin bad++; $display("FAIL align_recover got resp=%0b exp 0", rs0); end
`else
    total++; if (ro0 !== 1'b1 || rs0 !== 1'b0) begin
      bad++; $display("FAIL align_okay got ready=%0b resp=%0b exp 1/0", ro0, rs0); end
    total++; if (rd0 !== 32'hCAFEF00D) begin bad++; $display("FAIL align_rdata got=%h exp=cafef00d", rd0); end
    tick();
`endif
  endtask

  task automatic test_reset_mid;
    addr_ph(2, 1'b1, 32'h030, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    HWDATA = 32'h5A5A5A5A;
    wait_rdy(2);
    tick();
    addr_ph(2, 1'b1, 32'h030, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    HWDATA = 32'h0BADF00D;
    total++; if (ro2 !== 1'b0) begin bad++; $display("FAIL rstmid_wait got ready=%0b exp 0", ro2); end
    HRESETn = 1'b0;
    tick();
    total++; if (ro2 !== 1'b1 || rs2 !== 1'b0 || rd2 !== 32'd0) begin
      bad++; $display("FAIL rstmid_outputs got ready=%0b resp=%0b rdata=%h exp 1/0/0", ro2, rs2, rd2); end
    HRESETn = 1'b1;
    addr_ph(2, 1'b0, 32'h030, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    wait_rdy(2);
    total++; if (rd2 !== 32'h5A5A5A5A) begin bad++; $display("FAIL rstmid_nowrite got=%h exp=5a5a5a5a", rd2); end
    tick();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    HRESETn = 1'b0;
    HADDR   = 32'd0;
    HWRITE  = 1'b0;
    HSIZE   = HSIZE_WORD;
    HTRANS  = HTRANS_IDLE;
    HWDATA  = 32'd0;
    sel0    = 1'b0;
    sel2    = 1'b0;
    sel3    = 1'b0;
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_error();
    test_align();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
